// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared pipeline-control types and constants
package riscv_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } ctrl_state_t;

    // Architectural zero register; writes to it never create a hazard.
    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
    } pipe_ctrl_t;

    // Whole pipeline frozen, no bubbles.
    localparam pipe_ctrl_t CTRL_HOLD   = 7'b00000_00;
    // Normal advance.
    localparam pipe_ctrl_t CTRL_ADV    = 7'b11111_00;
    // Taken branch: everything advances, the two younger stages are squashed.
    localparam pipe_ctrl_t CTRL_BRANCH = 7'b11111_11;
    // Load-use: PC and IF/ID hold, one bubble goes into EX.
    localparam pipe_ctrl_t CTRL_LDUSE  = 7'b00111_01;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard compare
module hazard_detect
    import riscv_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      id_uses_rs1,
    input  logic                      id_uses_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      ex_mem_read,
    output logic                      load_use
);

    logic rs1_hit;
    logic rs2_hit;

    // A load writing x0 never produces a value anyone waits for.
    always_comb begin
        rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
        rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
        load_use = ex_mem_read && (ex_rd != REG_ADDR_WIDTH'(REG_ZERO)) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush controller; perf counters under PIPE_CTRL_PERF_EN
module pipe_hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MAX_MEM_WAIT   = 16,
    parameter int WAIT_CNT_WIDTH = $clog2(MAX_MEM_WAIT + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      id_uses_rs1,
    input  logic                      id_uses_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      ex_mem_read,
    input  logic                      ex_branch_taken,
    input  logic                      mem_req,
    input  logic                      mem_ready,
    output logic                      pc_en,
    output logic                      if_id_en,
    output logic                      id_ex_en,
    output logic                      ex_mem_en,
    output logic                      mem_wb_en,
    output logic                      if_id_flush,
    output logic                      id_ex_flush,
    output logic                      mem_timeout,
    output logic [31:0]               perf_stall_cnt,
    output logic [31:0]               perf_flush_cnt
);

    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_MAX = WAIT_CNT_WIDTH'(MAX_MEM_WAIT);

    ctrl_state_t                state_q, state_d;
    logic [WAIT_CNT_WIDTH-1:0]  wait_cnt_q, wait_cnt_d;
    logic                       mem_timeout_q, mem_timeout_d;
    logic                       load_use;
    logic                       mem_stall;
    pipe_ctrl_t                 adv_ctrl;
    pipe_ctrl_t                 fsm_ctrl;
    pipe_ctrl_t                 ctrl;

    hazard_detect #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    // Control for a cycle in which memory is not holding us: branch squash beats load-use.
    always_comb begin
        mem_stall = mem_req && !mem_ready;
        if (ex_branch_taken) begin
            adv_ctrl = CTRL_BRANCH;
        end else if (load_use) begin
            adv_ctrl = CTRL_LDUSE;
        end else begin
            adv_ctrl = CTRL_ADV;
        end
    end

    // Next-state and stage controls; a dropped mem_req during a wait counts as completion.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        fsm_ctrl      = CTRL_HOLD;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_CNT_WIDTH'(1);
                end else begin
                    fsm_ctrl = adv_ctrl;
                end
            end
            MEM_WAIT: begin
                if (!mem_stall) begin
                    fsm_ctrl   = adv_ctrl;
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_MAX) begin
                    state_d       = FAULT;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_CNT_WIDTH'(1);
                end
            end
            FAULT: begin
                mem_timeout_d = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Reset forces every stage register idle regardless of state.
    always_comb begin
        ctrl = reset ? CTRL_HOLD : fsm_ctrl;
    end

    assign pc_en       = ctrl.pc_en;
    assign if_id_en    = ctrl.if_id_en;
    assign id_ex_en    = ctrl.id_ex_en;
    assign ex_mem_en   = ctrl.ex_mem_en;
    assign mem_wb_en   = ctrl.mem_wb_en;
    assign if_id_flush = ctrl.if_id_flush;
    assign id_ex_flush = ctrl.id_ex_flush;
    assign mem_timeout = mem_timeout_q;

    // Controller state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
    logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;

    // Any cycle the PC is held counts as a stall, including FAULT.
    always_comb begin
        perf_stall_cnt_d = perf_stall_cnt_q + {31'd0, !ctrl.pc_en};
        perf_flush_cnt_d = perf_flush_cnt_q + {31'd0, ctrl.if_id_flush};
    end

    // Free-running, wrapping performance counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cnt_q <= '0;
            perf_flush_cnt_q <= '0;
        end else begin
            perf_stall_cnt_q <= perf_stall_cnt_d;
            perf_flush_cnt_q <= perf_flush_cnt_d;
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_q;
    assign perf_flush_cnt = perf_flush_cnt_q;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

endmodule
